// File: rtl/sparc_exu_yreg_wctl_pkg.sv
// Shared definitions for the Y register write-control sequencer:
// pipe entry kind encoding, default sizes and the pipe entry record.
package sparc_exu_yreg_wctl_pkg;

    localparam int YREG_NTHR   = 4;
    localparam int YREG_YCNT_W = 3;

    typedef enum logic [1:0] {
        KIND_WRY  = 2'd0,
        KIND_MULS = 2'd1,
        KIND_MUL  = 2'd2
    } ykind_e;

    typedef struct packed {
        logic                 vld;
        ykind_e               kind;
        logic [YREG_NTHR-1:0] thr;
        logic                 d31;
    } ypipe_t;

    // Kind of the E instruction; only meaningful when exactly one valid is set.
    function automatic ykind_e kind_from_e(input logic wry, input logic muls);
        if (wry) begin
            return KIND_WRY;
        end else if (muls) begin
            return KIND_MULS;
        end
        return KIND_MUL;
    endfunction

endpackage

// File: rtl/sparc_exu_yreg_thrcnt.sv
// Per-thread pending Y write counter: one increment and up to four
// decrements per cycle, saturating at the top and clamping at zero.
// busy is registered and reflects the count after the last update.
module sparc_exu_yreg_thrcnt
    import sparc_exu_yreg_wctl_pkg::*;
#(
    parameter int YCNT_W = YREG_YCNT_W
) (
    input  logic       clk,
    input  logic       arst_l,
    input  logic       i_inc,
    input  logic [2:0] i_ndec,
    output logic       o_busy
);

    localparam int CNT_MAX = (1 << YCNT_W) - 1;

    logic [YCNT_W-1:0] r_cnt;
    logic [YCNT_W-1:0] w_cnt_nxt;
    logic              r_busy;
    int                w_sum;

    // Net change this cycle, clamped into [0, CNT_MAX]
    always_comb begin
        w_sum     = int'(r_cnt) + int'(i_inc) - int'(i_ndec);
        w_cnt_nxt = '0;
        if (w_sum > CNT_MAX) begin
            w_cnt_nxt = YCNT_W'(CNT_MAX);
        end else if (w_sum > 0) begin
            w_cnt_nxt = YCNT_W'(w_sum);
        end
    end

    // Count and busy flag registers
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/sparc_exu_yreg_wctl.sv
// Y register write-control sequencer. Carries WRY / MULScc / UMUL-SMUL
// entries through M, W, W2 and merges them with multiplier returns at G
// into per-thread write, shift and hold selects.
// Optional macro EXU_YREG_SB_EN: adds the per-thread pending-write
// scoreboard driving yreg_busy; without it yreg_busy is tied low.
module sparc_exu_yreg_wctl
    import sparc_exu_yreg_wctl_pkg::*;
#(
    parameter int NTHR   = YREG_NTHR,
    parameter int YCNT_W = YREG_YCNT_W
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic            se,
    input  logic [NTHR-1:0] ecl_thr_e,
    input  logic            ecl_wry_vld_e,
    input  logic            ecl_muls_vld_e,
    input  logic            ecl_mulywr_vld_e,
    input  logic            ecl_kill_m,
    input  logic            ecl_kill_w,
    input  logic            byp_muls_rs1_0_w,
    input  logic            mul_ydone_g,
    input  logic [NTHR-1:0] mul_thr_g,
    output logic [NTHR-1:0] yreg_wen_w,
    output logic [NTHR-1:0] yreg_wen_g,
    output logic [NTHR-1:0] yreg_wen_l,
    output logic [NTHR-1:0] yreg_shift_g,
    output logic            yreg_data_31_g,
    output logic [NTHR-1:0] yreg_busy,
    output logic            yreg_collide
);

    logic            w_cap_e;
    ykind_e          w_kind_e;
    ypipe_t          r_m;
    ypipe_t          r_w;
    ypipe_t          r_w2;
    logic [NTHR-1:0] w_sel_w;
    logic [NTHR-1:0] w_sel_s;
    logic [NTHR-1:0] w_shift;
    logic [NTHR-1:0] w_g_raw;
    logic [NTHR-1:0] w_wen_g;
    logic            w_unused;

    // Ambiguous E cycles (zero or several valids) are not tracked at all
    assign w_cap_e  = (ecl_wry_vld_e ^ ecl_muls_vld_e ^ ecl_mulywr_vld_e) &
                      ~(ecl_wry_vld_e & ecl_muls_vld_e & ecl_mulywr_vld_e);
    assign w_kind_e = kind_from_e(ecl_wry_vld_e, ecl_muls_vld_e);

    // Advance E -> M -> W -> W2; each kill drops the entry at its stage
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_m  <= '0;
            r_w  <= '0;
            r_w2 <= '0;
        end else begin
            r_m.vld  <= w_cap_e;
            r_m.kind <= w_kind_e;
            r_m.thr  <= ecl_thr_e;
            r_m.d31  <= 1'b0;
            r_w      <= r_m;
            r_w.vld  <= r_m.vld & ~ecl_kill_m;
            r_w2     <= r_w;
            r_w2.vld <= r_w.vld & ~ecl_kill_w;
            r_w2.d31 <= byp_muls_rs1_0_w;
        end
    end

    // W2 decode; MUL entries retire silently since their data comes at G
    assign w_sel_w = (r_w2.vld && (r_w2.kind == KIND_WRY))  ? r_w2.thr : '0;
    assign w_sel_s = (r_w2.vld && (r_w2.kind == KIND_MULS)) ? r_w2.thr : '0;

    // Same-thread priority: WRY write, then MULScc shift, then multiplier
    assign w_shift = w_sel_s & ~w_sel_w;
    assign w_g_raw = mul_ydone_g ? mul_thr_g : '0;
    assign w_wen_g = w_g_raw & ~(w_sel_w | w_shift);

    assign yreg_wen_w     = w_sel_w;
    assign yreg_shift_g   = w_shift;
    assign yreg_wen_g     = w_wen_g;
    assign yreg_wen_l     = ~(w_sel_w | w_shift | w_wen_g);
    assign yreg_data_31_g = r_w2.d31 & (|w_shift);
    assign yreg_collide   = |(w_g_raw & (w_sel_w | w_shift));

`ifdef EXU_YREG_SB_EN
    logic [NTHR-1:0] w_dec_m;
    logic [NTHR-1:0] w_dec_w;
    logic [NTHR-1:0] w_dec_w2;

    // Every way an outstanding write can stop being outstanding
    assign w_dec_m  = (r_m.vld & ecl_kill_m) ? r_m.thr : '0;
    assign w_dec_w  = (r_w.vld & ecl_kill_w) ? r_w.thr : '0;
    assign w_dec_w2 = w_sel_w | w_sel_s;

    for (genvar gi = 0; gi < NTHR; gi++) begin : g_thr
        logic       w_inc;
        logic [2:0] w_ndec;

        assign w_inc  = w_cap_e & ecl_thr_e[gi];
        assign w_ndec = {2'b00, w_dec_m[gi]} + {2'b00, w_dec_w[gi]} +
                        {2'b00, w_dec_w2[gi]} + {2'b00, w_g_raw[gi]};

        sparc_exu_yreg_thrcnt #(
            .YCNT_W (YCNT_W)
        ) u_cnt (
            .clk    (clk),
            .arst_l (arst_l),
            .i_inc  (w_inc),
            .i_ndec (w_ndec),
            .o_busy (yreg_busy[gi])
        );
    end
`else
    assign yreg_busy = '0;
`endif

    // Scan enable has no functional role; M/W d31 slots are never read
    assign w_unused = ^{se, r_m.d31, r_w.d31};

endmodule

// File: tb/tb_sparc_exu_yreg_wctl.sv
// Self-checking bench for sparc_exu_yreg_wctl: table of single-instruction
// scenarios, directed multi-cycle sequences and a randomized run checked
// against a cycle-history reference model.
module tb_sparc_exu_yreg_wctl;

    localparam int NT = 4;
    localparam int HN = 4096;
`ifdef EXU_YREG_SB_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic          clk;
    logic          arst_l;
    logic          se;
    logic [NT-1:0] ecl_thr_e;
    logic          ecl_wry_vld_e;
    logic          ecl_muls_vld_e;
    logic          ecl_mulywr_vld_e;
    logic          ecl_kill_m;
    logic          ecl_kill_w;
    logic          byp_muls_rs1_0_w;
    logic          mul_ydone_g;
    logic [NT-1:0] mul_thr_g;
    logic [NT-1:0] yreg_wen_w;
    logic [NT-1:0] yreg_wen_g;
    logic [NT-1:0] yreg_wen_l;
    logic [NT-1:0] yreg_shift_g;
    logic          yreg_data_31_g;
    logic [NT-1:0] yreg_busy;
    logic          yreg_collide;

    sparc_exu_yreg_wctl dut (
        .clk              (clk),
        .arst_l           (arst_l),
        .se               (se),
        .ecl_thr_e        (ecl_thr_e),
        .ecl_wry_vld_e    (ecl_wry_vld_e),
        .ecl_muls_vld_e   (ecl_muls_vld_e),
        .ecl_mulywr_vld_e (ecl_mulywr_vld_e),
        .ecl_kill_m       (ecl_kill_m),
        .ecl_kill_w       (ecl_kill_w),
        .byp_muls_rs1_0_w (byp_muls_rs1_0_w),
        .mul_ydone_g      (mul_ydone_g),
        .mul_thr_g        (mul_thr_g),
        .yreg_wen_w       (yreg_wen_w),
        .yreg_wen_g       (yreg_wen_g),
        .yreg_wen_l       (yreg_wen_l),
        .yreg_shift_g     (yreg_shift_g),
        .yreg_data_31_g   (yreg_data_31_g),
        .yreg_busy        (yreg_busy),
        .yreg_collide     (yreg_collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle of what was applied; the model reads it back by age
    typedef struct {
        bit         rst;
        bit         cap;
        int         kind;   // 0 WRY, 1 MULScc, 2 MUL
        logic [3:0] thr;
        bit         km;
        bit         kw;
        bit         byp;
        logic [3:0] graw;
    } hist_t;

    typedef struct {
        bit         wry, muls, mul;
        logic [3:0] thr;
        bit         km, kw, byp, gv;
        logic [3:0] gthr;
        logic [3:0] x_w, x_s;
        bit         x_d31;
        logic [3:0] x_g, x_l;
        bit         x_col;
    } vec_t;

    hist_t hist [HN];
    int    pend [NT];
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;

    bit         s_rst, s_wry, s_muls, s_mul, s_km, s_kw, s_byp, s_g;
    logic [3:0] s_thr, s_gthr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit live_m(input int n);
        if (n < 0) return 1'b0;
        return hist[n].cap && !hist[n].rst && !hist[n+1].rst;
    endfunction

    function automatic bit live_w(input int n);
        if (!live_m(n)) return 1'b0;
        return !hist[n+1].km && !hist[n+2].rst;
    endfunction

    function automatic bit live_w2(input int n);
        if (!live_w(n)) return 1'b0;
        return !hist[n+2].kw && !hist[n+3].rst;
    endfunction

    // Apply staged inputs after the edge, predict and compare at the falling edge
    task automatic run_cycle();
        logic [3:0] e_w, e_s, e_g, e_l, e_busy, gr;
        bit         e_d31, e_col;
        int         n, v;
        @(posedge clk);
        #1;
        if (cyc >= HN - 1) begin
            $display("FAIL hist_overflow cyc=%0d limit=%0d", cyc, HN);
            $fatal(1);
        end
        arst_l           = ~s_rst;
        ecl_wry_vld_e    = s_wry;
        ecl_muls_vld_e   = s_muls;
        ecl_mulywr_vld_e = s_mul;
        ecl_thr_e        = s_thr;
        ecl_kill_m       = s_km;
        ecl_kill_w       = s_kw;
        byp_muls_rs1_0_w = s_byp;
        mul_ydone_g      = s_g;
        mul_thr_g        = s_gthr;
        hist[cyc].rst  = s_rst;
        hist[cyc].cap  = ((int'(s_wry) + int'(s_muls) + int'(s_mul)) == 1);
        hist[cyc].kind = s_wry ? 0 : (s_muls ? 1 : 2);
        hist[cyc].thr  = s_thr;
        hist[cyc].km   = s_km;
        hist[cyc].kw   = s_kw;
        hist[cyc].byp  = s_byp;
        hist[cyc].graw = s_g ? s_gthr : 4'b0000;
        {s_rst, s_wry, s_muls, s_mul, s_km, s_kw, s_byp, s_g} = '0;
        s_thr  = 4'b0000;
        s_gthr = 4'b0000;

        @(negedge clk);
        e_w = 4'b0000; e_s = 4'b0000; e_d31 = 1'b0;
        n = cyc - 3;
        if (live_w2(n)) begin
            if (hist[n].kind == 0) e_w = hist[n].thr;
            else if (hist[n].kind == 1) begin
                e_s   = hist[n].thr;
                e_d31 = hist[n+2].byp;
            end
        end
        gr    = hist[cyc].graw;
        e_g   = gr & ~(e_w | e_s);
        e_col = |(gr & (e_w | e_s));
        e_l   = ~(e_w | e_s | e_g);
        if (e_s == 4'b0000) e_d31 = 1'b0;
        for (int t = 0; t < NT; t++)
            e_busy[t] = SB_EN && !hist[cyc].rst && (pend[t] != 0);
        chk("mdl_wen_w",   yreg_wen_w,     e_w);
        chk("mdl_shift",   yreg_shift_g,   e_s);
        chk("mdl_data31",  yreg_data_31_g, e_d31);
        chk("mdl_wen_g",   yreg_wen_g,     e_g);
        chk("mdl_wen_l",   yreg_wen_l,     e_l);
        chk("mdl_collide", yreg_collide,   e_col);
        chk("mdl_busy",    yreg_busy,      e_busy);

        for (int t = 0; t < NT; t++) begin
            if (hist[cyc].rst) begin
                pend[t] = 0;
            end else begin
                v = pend[t];
                if (hist[cyc].cap && hist[cyc].thr[t]) v++;
                if (live_m(cyc - 1)) if (hist[cyc].km && hist[cyc-1].thr[t]) v--;
                if (live_w(cyc - 2)) if (hist[cyc].kw && hist[cyc-2].thr[t]) v--;
                if (e_w[t] || e_s[t]) v--;
                if (gr[t]) v--;
                if (v < 0) v = 0;
                if (v > 7) v = 7;
                pend[t] = v;
            end
        end
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d limit=%0d", cyc, 500000);
        $fatal(1);
    end

    vec_t vt [10];

    initial begin
        vt[0] = '{1,0,0,4'b0010,0,0,0,0,4'b0000, 4'b0010,4'b0000,0,4'b0000,4'b1101,0};
        vt[1] = '{0,1,0,4'b0001,0,0,1,0,4'b0000, 4'b0000,4'b0001,1,4'b0000,4'b1110,0};
        vt[2] = '{0,1,0,4'b0100,0,0,0,0,4'b0000, 4'b0000,4'b0100,0,4'b0000,4'b1011,0};
        vt[3] = '{1,0,0,4'b0100,1,0,0,0,4'b0000, 4'b0000,4'b0000,0,4'b0000,4'b1111,0};
        vt[4] = '{1,0,0,4'b1000,0,0,0,1,4'b1000, 4'b1000,4'b0000,0,4'b0000,4'b0111,1};
        vt[5] = '{1,0,0,4'b1000,0,0,0,1,4'b0001, 4'b1000,4'b0000,0,4'b0001,4'b0110,0};
        vt[6] = '{0,1,0,4'b0010,0,0,1,1,4'b0010, 4'b0000,4'b0010,1,4'b0000,4'b1101,1};
        vt[7] = '{0,0,1,4'b0001,0,0,0,1,4'b0001, 4'b0000,4'b0000,0,4'b0001,4'b1110,0};
        vt[8] = '{0,1,0,4'b1000,0,1,1,0,4'b0000, 4'b0000,4'b0000,0,4'b0000,4'b1111,0};
        vt[9] = '{1,1,0,4'b0001,0,0,0,0,4'b0000, 4'b0000,4'b0000,0,4'b0000,4'b1111,0};

        for (int t = 0; t < NT; t++) pend[t] = 0;
        se = 1'b0; arst_l = 1'b0;
        ecl_thr_e = '0; ecl_wry_vld_e = 0; ecl_muls_vld_e = 0; ecl_mulywr_vld_e = 0;
        ecl_kill_m = 0; ecl_kill_w = 0; byp_muls_rs1_0_w = 0; mul_ydone_g = 0; mul_thr_g = '0;
        {s_rst, s_wry, s_muls, s_mul, s_km, s_kw, s_byp, s_g} = '0;
        s_thr = '0; s_gthr = '0;

        // Reset state
        s_rst = 1; run_cycle();
        s_rst = 1; run_cycle();
        run_cycle();
        chk("rst_wen_w", yreg_wen_w, 4'b0000);
        chk("rst_wen_l", yreg_wen_l, 4'b1111);
        chk("rst_busy",  yreg_busy,  4'b0000);
        chk("rst_d31",   yreg_data_31_g, 1'b0);

        // Single-instruction scenarios, outputs compared at the W2 cycle
        for (int i = 0; i < 10; i++) begin
            s_rst = 1; run_cycle();
            s_wry = vt[i].wry; s_muls = vt[i].muls; s_mul = vt[i].mul; s_thr = vt[i].thr;
            run_cycle();
            s_km = vt[i].km; run_cycle();
            s_kw = vt[i].kw; s_byp = vt[i].byp; run_cycle();
            s_g = vt[i].gv; s_gthr = vt[i].gthr; run_cycle();
            chk($sformatf("tbl%0d_wen_w", i),   yreg_wen_w,     vt[i].x_w);
            chk($sformatf("tbl%0d_shift", i),   yreg_shift_g,   vt[i].x_s);
            chk($sformatf("tbl%0d_d31", i),     yreg_data_31_g, vt[i].x_d31);
            chk($sformatf("tbl%0d_wen_g", i),   yreg_wen_g,     vt[i].x_g);
            chk($sformatf("tbl%0d_wen_l", i),   yreg_wen_l,     vt[i].x_l);
            chk($sformatf("tbl%0d_collide", i), yreg_collide,   vt[i].x_col);
        end

        // WRY thr1: select only at cycle 3, busy over cycles 1..3
        s_rst = 1; run_cycle();
        s_wry = 1; s_thr = 4'b0010; run_cycle();
        chk("seqA_busy_c0", yreg_busy[1], 1'b0);
        chk("seqA_wen_c0",  yreg_wen_w, 4'b0000);
        for (int k = 1; k <= 4; k++) begin
            run_cycle();
            chk($sformatf("seqA_wen_c%0d", k),  yreg_wen_w, (k == 3) ? 4'b0010 : 4'b0000);
            chk($sformatf("seqA_busy_c%0d", k), yreg_busy[1], (k <= 3) ? SB_EN : 1'b0);
        end

        // WRY thr2 killed in M
        s_rst = 1; run_cycle();
        s_wry = 1; s_thr = 4'b0100; run_cycle();
        s_km = 1; run_cycle();
        run_cycle();
        chk("seqB_busy_c2", yreg_busy[2], 1'b0);
        run_cycle();
        chk("seqB_wen_c3", yreg_wen_w, 4'b0000);

        // Saturation: 8 MUL issues then returns
        s_rst = 1; run_cycle();
        for (int k = 0; k < 8; k++) begin
            s_mul = 1; s_thr = 4'b0001; run_cycle();
        end
        run_cycle(); run_cycle(); run_cycle();
        chk("seqC_busy_sat", yreg_busy[0], SB_EN);
        for (int k = 0; k < 6; k++) begin
            s_g = 1; s_gthr = 4'b0001; run_cycle();
        end
        run_cycle();
        chk("seqC_busy_6ret", yreg_busy[0], SB_EN);
        s_g = 1; s_gthr = 4'b0001; run_cycle();
        chk("seqC_wen_g", yreg_wen_g, 4'b0001);
        run_cycle();
        chk("seqC_busy_7ret", yreg_busy[0], 1'b0);

        // Reset with three entries in flight
        s_rst = 1; run_cycle();
        s_wry = 1;  s_thr = 4'b0001; run_cycle();
        s_wry = 1;  s_thr = 4'b0010; run_cycle();
        s_muls = 1; s_thr = 4'b0100; run_cycle();
        s_rst = 1; run_cycle();
        chk("seqD_wen_rst",  yreg_wen_w, 4'b0000);
        chk("seqD_busy_rst", yreg_busy, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            run_cycle();
            chk($sformatf("seqD_wen_w_%0d", k), yreg_wen_w, 4'b0000);
            chk($sformatf("seqD_shift_%0d", k), yreg_shift_g, 4'b0000);
            chk($sformatf("seqD_wen_l_%0d", k), yreg_wen_l, 4'b1111);
            chk($sformatf("seqD_busy_%0d", k),  yreg_busy, 4'b0000);
        end

        // Randomized traffic against the history model
        for (int k = 0; k < 1200; k++) begin
            int r;
            r = $urandom_range(0, 7);
            s_wry  = (r <= 1) || (r == 6);
            s_muls = (r == 2) || (r == 3);
            s_mul  = (r == 4) || (r == 5) || (r == 6);
            s_thr  = 4'(1 << $urandom_range(0, 3));
            s_km   = ($urandom_range(0, 7) == 0);
            s_kw   = ($urandom_range(0, 7) == 0);
            s_byp  = ($urandom_range(0, 1) == 1);
            s_g    = ($urandom_range(0, 2) == 0);
            s_gthr = 4'(1 << $urandom_range(0, 3));
            s_rst  = ($urandom_range(0, 149) == 0);
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
